if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipelined CPU.
- Owns the 9-bit PC, drives the instruction-memory address, and latches the fetched word with its PC and PC+8.
- Feeds the ID stage (decoder, register file, control unit), which in turn feeds the ID/EX register.
- Handles load-use stalls (le=0), taken-branch/jump redirect from the EX condition handler, and flush bubbles.

Parameters:
- RESET_PC, 9'd0, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- le  input  1  load enable from the hazard unit; 0 = stall (hold PC and IF/ID).
- flush  input  1  external squash of IF/ID; inserts NOP_WORD.
- branch_taken  input  1  from the condition handler in EX; redirect request.
- targetAddress  input  9  branch/jump target; bits [1:0] are ignored and treated as 00.
- imem_data  input  32  instruction word read combinationally at imem_addr.
- imem_addr  output  9  current PC; driven directly from the PC register.
- ID_instr  output  32  latched instruction word.
- ID_opcode  output  6  ID_instr[31:26].
- ID_rs  output  5  ID_instr[25:21].
- ID_rt  output  5  ID_instr[20:16].
- ID_rd  output  5  ID_instr[15:11].
- ID_imm16  output  16  ID_instr[15:0].
- ID_PC  output  9  PC of the instruction in ID.
- ID_PC8  output  9  ID_PC + 8, modulo 512; return address for jal/bal.
- ID_valid  output  1  1 = ID holds a real instruction; 0 = bubble.
- redirect_pending  output  1  a redirect was received during a stall and has not yet been applied.

Behaviour:
- Reset (synchronous, highest priority):
  - PC=RESET_PC, ID_instr=NOP_WORD, ID_PC=0, ID_PC8=0, ID_valid=0.
  - Pending register: valid=0, target=0.
  - Decoded field outputs are therefore all 0.
- Decoded fields are pure combinational slices of ID_instr and add no latency.
- Define eff_ta = {targetAddress[8:2],2'b00}.
- Define redirect = pend_valid OR branch_taken. The target is pend_ta if pend_valid, else eff_ta: an older pending redirect wins, and a live branch_taken in the same cycle is discarded.
- Per posedge when reset=0, the first matching case applies:
  1. le=0 (stall):
     - PC and all IF/ID registers hold.
     - If branch_taken=1 and pend_valid=0: pend_valid<=1, pend_ta<=eff_ta.
     - If branch_taken=1 and pend_valid=1: ignored, first target kept.
     - flush is ignored while stalled; the hazard unit re-asserts it.
  2. le=1 and redirect=1:
     - PC<=target.
     - IF/ID<=NOP_WORD, ID_valid<=0, ID_PC/ID_PC8 hold. The wrong-path word at PC+4 past the delay slot is squashed; the delay slot is already in ID and proceeds.
     - pend_valid<=0.
  3. le=1 and flush=1:
     - PC<=PC+4.
     - IF/ID<=NOP_WORD, ID_valid<=0.
  4. le=1 (normal):
     - PC<=PC+4.
     - ID_instr<=imem_data, ID_PC<=PC, ID_PC8<=PC+8, ID_valid<=1.
- Arithmetic: all PC math is 9-bit and wraps modulo 512. PC=508 gives next PC 0, and ID_PC8 for PC 504 is 0.
- PC[1:0] is always 00: reset value and targets are word aligned.
- Latency:
  - Fetch to ID visibility is 1 cycle.
  - Redirect to first target-instruction fetch: imem_addr=target in the cycle after the redirect edge.
- redirect_pending = pend_valid (registered).
- No combinational path from any input to any output; imem_addr depends only on the PC register.

Test Plan:
- Reset then 4 cycles le=1, imem_data = 0x11,0x22,0x33,0x44 at PC 0,4,8,12 -> imem_addr 0,4,8,12,16; ID_instr 0x22 with ID_PC=4, ID_PC8=12, ID_valid=1 after 2nd edge.
- Load-use stall: PC=20, le=0 for 2 cycles -> imem_addr stays 20; ID_instr/ID_PC unchanged; resumes with PC=24 on the first le=1 edge.
- branch_taken=1, targetAddress=9'd102, PC=40, le=1 -> next imem_addr=100, ID_valid=0, ID_instr=0; following edge latches imem_data with ID_PC=100, ID_PC8=108.
- Stall + redirect: le=0, branch_taken=1, TA=200 -> redirect_pending=1, PC held. Next cycle le=1, branch_taken=1, TA=300 -> PC=200 (pending wins), redirect_pending=0.
- Wrap: PC=504, le=1 for 2 cycles -> imem_addr 508 then 0; ID_PC=504 with ID_PC8=0.
- Reset mid-operation: redirect_pending=1, ID_valid=1, assert reset one cycle -> next cycle PC=0, ID_valid=0, redirect_pending=0, ID_instr=0.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, drives the
// instruction-memory address and hands the fetched word, its PC and PC+8 to ID.
module if_id_stage #(
   parameter logic [8:0]  RESET_PC = 9'd0,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        le,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [8:0]  targetAddress,
   input  logic [31:0] imem_data,
   output logic [8:0]  imem_addr,
   output logic [31:0] ID_instr,
   output logic [5:0]  ID_opcode,
   output logic [4:0]  ID_rs,
   output logic [4:0]  ID_rt,
   output logic [4:0]  ID_rd,
   output logic [15:0] ID_imm16,
   output logic [8:0]  ID_PC,
   output logic [8:0]  ID_PC8,
   output logic        ID_valid,
   output logic        redirect_pending
);

   logic [8:0]  pc_q,       pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [8:0]  id_pc_q,    id_pc_d;
   logic [8:0]  id_pc8_q,   id_pc8_d;
   logic        id_valid_q, id_valid_d;
   logic        pend_valid_q, pend_valid_d;
   logic [8:0]  pend_ta_q,  pend_ta_d;

   logic [8:0]  eff_ta_s;
   logic [8:0]  redir_target_s;
   logic        redirect_s;
   logic [8:0]  pc_plus4_s;
   logic [8:0]  pc_plus8_s;
   logic        ta_unused_s;

   // Targets are word aligned; the two low address bits carry no information.
   assign ta_unused_s = ^targetAddress[1:0];

   // Next-state selection: stall, then redirect, then flush, then normal fetch.
   always_comb begin
      eff_ta_s       = {targetAddress[8:2], 2'b00};
      redirect_s     = pend_valid_q | branch_taken;
      redir_target_s = pend_valid_q ? pend_ta_q : eff_ta_s;
      pc_plus4_s     = pc_q + 9'd4;
      pc_plus8_s     = pc_q + 9'd8;

      pc_d         = pc_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pc8_d     = id_pc8_q;
      id_valid_d   = id_valid_q;
      pend_valid_d = pend_valid_q;
      pend_ta_d    = pend_ta_q;

      if (!le) begin
         // Remember only the first redirect seen while stalled.
         if (branch_taken && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_ta_d    = eff_ta_s;
         end else begin
            pend_valid_d = pend_valid_q;
            pend_ta_d    = pend_ta_q;
         end
      end else if (redirect_s) begin
         pc_d         = redir_target_s;
         id_instr_d   = NOP_WORD;
         id_valid_d   = 1'b0;
         pend_valid_d = 1'b0;
      end else if (flush) begin
         pc_d       = pc_plus4_s;
         id_instr_d = NOP_WORD;
         id_valid_d = 1'b0;
      end else begin
         pc_d       = pc_plus4_s;
         id_instr_d = imem_data;
         id_pc_d    = pc_q;
         id_pc8_d   = pc_plus8_s;
         id_valid_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         id_instr_q   <= NOP_WORD;
         id_pc_q      <= 9'd0;
         id_pc8_q     <= 9'd0;
         id_valid_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_ta_q    <= 9'd0;
      end else begin
         pc_q         <= pc_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_pc8_q     <= id_pc8_d;
         id_valid_q   <= id_valid_d;
         pend_valid_q <= pend_valid_d;
         pend_ta_q    <= pend_ta_d;
      end
   end

   assign imem_addr        = pc_q;
   assign ID_instr         = id_instr_q;
   assign ID_opcode        = id_instr_q[31:26];
   assign ID_rs            = id_instr_q[25:21];
   assign ID_rt            = id_instr_q[20:16];
   assign ID_rd            = id_instr_q[15:11];
   assign ID_imm16         = id_instr_q[15:0];
   assign ID_PC            = id_pc_q;
   assign ID_PC8           = id_pc8_q;
   assign ID_valid         = id_valid_q;
   assign redirect_pending = pend_valid_q;

endmodule
